cordic_job_queue: RTL and testbench
===================================

# cordic_job_queue

Buffered, flow-controlled job path between the host bus side and the CORDIC controller. The host pushes up to p_DEPTH operand/control sets without waiting. The block issues them to the controller in order with a valid/ready handshake and collects results into an equally deep result queue. A credit counter guarantees the result queue never overflows, and the block raises a level interrupt while results are pending.

## Interface

Parameters:
- p_WIDTH, 32, width of the x/y/z operands and of the control word
- p_DEPTH, 4, entries per queue; power of two, ≥2

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- cmdValid / cmdReady  input / output  1  host command handshake
- cmdX, cmdY, cmdZ  input  p_WIDTH each  signed operands
- cmdControl  input  p_WIDTH  unsigned control word, passed through unchanged
- jobValid / jobReady  output / input  1  job handshake to the controller
- jobX, jobY, jobZ, jobControl  output  p_WIDTH each  head command
- resValid  input  1  one-cycle result strobe from the controller; no backpressure
- resX, resY, resZ, resControl  input  p_WIDTH each  result data, qualified by resValid
- outValid / outReady  output / input  1  result handshake to the host
- outX, outY, outZ, outControl  output  p_WIDTH each  head result
- irqEnable  input  1  interrupt enable
- interrupt  output  1  registered; pending-result interrupt
- error  output  1  registered; sticky; result received with no job in flight
- cmdCount, resCount  output  $clog2(p_DEPTH)+1 each  queue occupancies

## Operation

- Command push: fires when cmdValid && cmdReady. cmdReady = !cmdFull && !rst. It never depends on a same-cycle pop.
- Job issue: jobValid = !cmdEmpty && credit.
  - credit = (resCount + inFlight) < p_DEPTH.
  - The head entry pops when jobValid && jobReady, and inFlight increments.
  - jobX/Y/Z/Control must hold stable while jobValid is high and jobReady is low.
- Result capture: when resValid && inFlight != 0, push {resX, resY, resZ, resControl} and decrement inFlight.
- Stray result: when resValid && inFlight == 0, drop the data and set error. error clears only on rst.
- Same-cycle issue and result: inFlight holds.
- Result pop: outValid = !resEmpty; pops on outValid && outReady.
  - Push and pop in the same cycle leave resCount unchanged.
  - A push into an empty queue is visible as outValid on the next cycle.
- Ordering: results are assumed in issue order; the block does not reorder.
- Pointers are $clog2(p_DEPTH) bits and wrap modulo p_DEPTH. Full/empty are derived from the occupancy counters, not from pointer compare.
- Reset clears both queues, inFlight, interrupt and error.
  - Mid-operation, in-flight jobs are discarded.
  - The controller shares rst.
  - resValid is ignored in a cycle where rst is high.

## Timing

- Reset values: cmdReady 0 during rst and 1 from the first cycle after; jobValid 0, outValid 0, interrupt 0, error 0, cmdCount 0, resCount 0.
- Command-to-job latency:
  - Command accepted at edge N, so jobValid is high after edge N; earliest job issue is at edge N+1.
  - With bypass (see Configuration), same-cycle issue.
- Result-to-host latency: a resValid sampled at edge N gives outValid high after edge N.
- interrupt is registered as irqEnable && (next resCount != 0).
  - It asserts one cycle after the first push with irqEnable high.
  - It drops one cycle after the last pop, or one cycle after irqEnable falls.
- Full: cmdCount == p_DEPTH forces cmdReady low that cycle, even if a pop also occurs.
- Max throughput: one command, one job and one result per cycle each.

## Configuration

- CORDIC_JOBQ_BYPASS_EN defined:
  - When the command queue is empty, credit is available and jobReady is high, an accepted command drives jobX/Y/Z/Control combinationally and issues in the same cycle without being written.
  - cmdCount stays 0.
- Not defined:
  - All commands pass through the queue. Minimum latency is one cycle.
  - There is no combinational path from cmd* to job*.

## Structure

- Shared package cordic_pkg holds:
  - function clog2 helpers for occupancy width
  - localparam defaults for p_WIDTH and p_DEPTH
  - the packed typedef cordic_word_set_t (x, y, z, control at 32 bits)
- One sub-module, cordic_sync_fifo:
  - parameters width and depth
  - push/pop/full/empty/count, synchronous active-high rst
  - instantiated twice with width 4*p_WIDTH

## Test plan

- Reset, then push 4 commands with jobReady=0 (p_DEPTH=4) → cmdCount=4, cmdReady=0. A 5th cmdValid is not accepted. jobX shows the 1st cmdX (0x0000_1000).
- Hold resultqueue full (4 results, outReady=0) → jobValid stays 0 despite a queued command. One outReady pop → jobValid rises the next cycle.
- Pulse resValid with no job issued → error=1 and resCount=0. error stays 1 until rst.
- irqEnable=1, one result pushed → interrupt=1 one cycle later. Pop it → interrupt=0 one cycle later. Set irqEnable=0 with a result pending → interrupt=0 next cycle.
- Assert rst for 1 cycle with 2 jobs in flight and 1 result queued → all counts 0 and outValid 0. A resValid afterwards sets error.
- With CORDIC_JOBQ_BYPASS_EN, empty queue, jobReady=1, push cmdZ=0x0C90_FDAA → jobValid and jobZ=0x0C90_FDAA in the same cycle, cmdCount stays 0.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : cordic_pkg                                                |
// | Brief    : Shared defaults, word-set type and width helpers for the  |
// |            CORDIC job queue.                                         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cordic_pkg;

  localparam int C_DEF_WIDTH = 32;
  localparam int C_DEF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] control;
  } cordic_word_set_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Occupancy counters must represent both 0 and a completely full queue.
  function automatic int occ_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cordic_sync_fifo                                          |
// | Brief    : Single-clock FIFO with occupancy counter, full/empty      |
// |            derived from the counter, synchronous active-high rst.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cordic_sync_fifo
  import cordic_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [occ_width(DEPTH)-1:0] count_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (w_push && !w_pop)      count_d = count_q + CW'(1);
    else if (!w_push && w_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/cordic_job_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cordic_job_queue                                          |
// | Brief    : Credit-controlled command/result queues between host and  |
// |            CORDIC controller. CORDIC_JOBQ_BYPASS_EN enables same-    |
// |            cycle issue of a command into an empty queue.             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cordic_job_queue
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = C_DEF_WIDTH,
  parameter int p_DEPTH = C_DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmdValid,
  output logic                          cmdReady,
  input  logic [p_WIDTH-1:0]            cmdX,
  input  logic [p_WIDTH-1:0]            cmdY,
  input  logic [p_WIDTH-1:0]            cmdZ,
  input  logic [p_WIDTH-1:0]            cmdControl,
  output logic                          jobValid,
  input  logic                          jobReady,
  output logic [p_WIDTH-1:0]            jobX,
  output logic [p_WIDTH-1:0]            jobY,
  output logic [p_WIDTH-1:0]            jobZ,
  output logic [p_WIDTH-1:0]            jobControl,
  input  logic                          resValid,
  input  logic [p_WIDTH-1:0]            resX,
  input  logic [p_WIDTH-1:0]            resY,
  input  logic [p_WIDTH-1:0]            resZ,
  input  logic [p_WIDTH-1:0]            resControl,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [p_WIDTH-1:0]            outX,
  output logic [p_WIDTH-1:0]            outY,
  output logic [p_WIDTH-1:0]            outZ,
  output logic [p_WIDTH-1:0]            outControl,
  input  logic                          irqEnable,
  output logic                          interrupt,
  output logic                          error,
  output logic [occ_width(p_DEPTH)-1:0] cmdCount,
  output logic [occ_width(p_DEPTH)-1:0] resCount
);

  localparam int CW = occ_width(p_DEPTH);
  localparam int SW = 4 * p_WIDTH;

  logic [SW-1:0] w_cmd_wdata, w_cmd_head, w_job_data;
  logic [SW-1:0] w_res_wdata, w_res_head;
  logic          w_cmd_full, w_cmd_empty;
  logic          w_res_full, w_res_empty;
  logic          w_credit, w_cmd_fire, w_bypass, w_issue;
  logic          w_res_valid, w_capture, w_stray, w_out_fire;
  logic [CW:0]   w_occ_sum;
  logic [CW-1:0] w_res_count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          error_q, interrupt_q;

  assign w_cmd_wdata = {cmdX, cmdY, cmdZ, cmdControl};
  assign w_res_wdata = {resX, resY, resZ, resControl};

  // Reserve a result slot for every job before it leaves, so the result queue cannot overflow.
  assign w_occ_sum = {1'b0, resCount} + {1'b0, inflight_q};
  assign w_credit  = !w_res_full && (w_occ_sum < (CW+1)'(p_DEPTH));

  assign cmdReady   = !w_cmd_full && !rst;
  assign w_cmd_fire = cmdValid && cmdReady;

`ifdef CORDIC_JOBQ_BYPASS_EN
  assign w_bypass   = w_cmd_empty && w_credit && jobReady && w_cmd_fire;
  assign w_job_data = w_bypass ? w_cmd_wdata : w_cmd_head;
`else
  assign w_bypass   = 1'b0;
  assign w_job_data = w_cmd_head;
`endif

  assign jobValid = !rst && ((!w_cmd_empty && w_credit) || w_bypass);
  assign w_issue  = jobValid && jobReady;
  assign {jobX, jobY, jobZ, jobControl} = w_job_data;

  assign w_res_valid = resValid && !rst;
  assign w_capture   = w_res_valid && (inflight_q != '0);
  assign w_stray     = w_res_valid && (inflight_q == '0);

  assign outValid   = !w_res_empty && !rst;
  assign w_out_fire = outValid && outReady;
  assign {outX, outY, outZ, outControl} = w_res_head;

  assign interrupt = interrupt_q;
  assign error     = error_q;

  cordic_sync_fifo #(.WIDTH(SW), .DEPTH(p_DEPTH)) u_cmd_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (w_cmd_fire && !w_bypass),
    .data_i (w_cmd_wdata),
    .pop_i  (w_issue && !w_bypass),
    .data_o (w_cmd_head),
    .full_o (w_cmd_full),
    .empty_o(w_cmd_empty),
    .count_o(cmdCount)
  );

  cordic_sync_fifo #(.WIDTH(SW), .DEPTH(p_DEPTH)) u_res_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (w_capture),
    .data_i (w_res_wdata),
    .pop_i  (w_out_fire),
    .data_o (w_res_head),
    .full_o (w_res_full),
    .empty_o(w_res_empty),
    .count_o(resCount)
  );

  always_comb begin
    inflight_d    = inflight_q;
    w_res_count_d = resCount;
    if (w_issue && !w_capture)      inflight_d = inflight_q + CW'(1);
    else if (!w_issue && w_capture) inflight_d = inflight_q - CW'(1);
    if (w_capture && !w_out_fire)      w_res_count_d = resCount + CW'(1);
    else if (!w_capture && w_out_fire) w_res_count_d = resCount - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= '0;
      error_q     <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      error_q     <= error_q || w_stray;
      interrupt_q <= irqEnable && (w_res_count_d != '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_job_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cordic_job_queue                                       |
// | Brief    : Queue-level reference model bench for cordic_job_queue.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_cordic_job_queue;
  import cordic_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk, rst;
  logic          cmdValid, cmdReady, jobValid, jobReady;
  logic          resValid, outValid, outReady, irqEnable, interrupt, error;
  logic [W-1:0]  cmdX, cmdY, cmdZ, cmdControl;
  logic [W-1:0]  jobX, jobY, jobZ, jobControl;
  logic [W-1:0]  resX, resY, resZ, resControl;
  logic [W-1:0]  outX, outY, outZ, outControl;
  logic [CW-1:0] cmdCount, resCount;

  cordic_job_queue #(.p_WIDTH(W), .p_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdX(cmdX), .cmdY(cmdY), .cmdZ(cmdZ), .cmdControl(cmdControl),
    .jobValid(jobValid), .jobReady(jobReady),
    .jobX(jobX), .jobY(jobY), .jobZ(jobZ), .jobControl(jobControl),
    .resValid(resValid),
    .resX(resX), .resY(resY), .resZ(resZ), .resControl(resControl),
    .outValid(outValid), .outReady(outReady),
    .outX(outX), .outY(outY), .outZ(outZ), .outControl(outControl),
    .irqEnable(irqEnable), .interrupt(interrupt), .error(error),
    .cmdCount(cmdCount), .resCount(resCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cordic_word_set_t cq[$];
  cordic_word_set_t rq[$];
  int m_inflight;
  bit m_err, m_irq;
  int checks, failures;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cordic_word_set_t cur_cmd();
    cordic_word_set_t c;
    c.x = cmdX; c.y = cmdY; c.z = cmdZ; c.control = cmdControl;
    return c;
  endfunction

  function automatic cordic_word_set_t cur_res();
    cordic_word_set_t c;
    c.x = resX; c.y = resY; c.z = resZ; c.control = resControl;
    return c;
  endfunction

  // Expected handshake levels for the current model state and inputs.
  task automatic model_comb(output bit rdy, output bit byp, output bit jv);
    bit credit;
    rdy    = (cq.size() < D);
    credit = (rq.size() + m_inflight) < D;
    byp    = 1'b0;
`ifdef CORDIC_JOBQ_BYPASS_EN
    byp = (cq.size() == 0) && credit && jobReady && cmdValid && rdy;
`endif
    jv = ((cq.size() != 0) && credit) || byp;
  endtask

  task automatic compare();
    bit rdy, byp, jv;
    cordic_word_set_t e;
    model_comb(rdy, byp, jv);
    chk("cmdReady", cmdReady, rdy);
    chk("jobValid", jobValid, jv);
    if (jv) begin
      e = byp ? cur_cmd() : cq[0];
      chk("jobData", {jobX, jobY, jobZ, jobControl}, e);
    end
    chk("outValid", outValid, rq.size() != 0);
    if (rq.size() != 0) chk("outData", {outX, outY, outZ, outControl}, rq[0]);
    chk("interrupt", interrupt, m_irq);
    chk("error", error, m_err);
    chk("cmdCount", cmdCount, cq.size());
    chk("resCount", resCount, rq.size());
  endtask

  task automatic model_update();
    bit rdy, byp, jv, issue, cap;
    if (rst) begin
      cq.delete(); rq.delete();
      m_inflight = 0; m_err = 1'b0; m_irq = 1'b0;
      return;
    end
    model_comb(rdy, byp, jv);
    issue = jv && jobReady;
    if (issue && !byp) void'(cq.pop_front());
    if (cmdValid && rdy && !byp) cq.push_back(cur_cmd());
    cap = resValid && (m_inflight != 0);
    if (resValid && m_inflight == 0) m_err = 1'b1;
    if ((rq.size() != 0) && outReady) void'(rq.pop_front());
    if (cap) rq.push_back(cur_res());
    m_inflight = m_inflight + int'(issue) - int'(cap);
    m_irq = irqEnable && (rq.size() != 0);
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    #1;
    if (!rst) compare();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cmdValid = 1'b0; jobReady = 1'b0; resValid = 1'b0; outReady = 1'b0;
  endtask

  task automatic rand_data();
    cmdX = $urandom; cmdY = $urandom; cmdZ = $urandom; cmdControl = $urandom;
    resX = $urandom; resY = $urandom; resZ = $urandom; resControl = $urandom;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_inflight = 0; m_err = 1'b0; m_irq = 1'b0;
    idle(); irqEnable = 1'b0; rst = 1'b1; rand_data();
    @(negedge clk);
    step(); step();
    rst = 1'b0;

    // Reset state.
    #1;
    chk("rst_cmdReady", cmdReady, 1'b1);
    chk("rst_jobValid", jobValid, 1'b0);
    chk("rst_outValid", outValid, 1'b0);
    chk("rst_counts", {cmdCount, resCount}, 6'd0);
    chk("rst_irq_err", {interrupt, error}, 2'b00);
    @(negedge clk);

    // Fill the command queue with no job acceptance.
    for (int i = 0; i < D; i++) begin
      rand_data(); cmdX = 32'h0000_1000 + 32'(i * 16); cmdValid = 1'b1;
      step();
    end
    chk("full_cmdCount", cmdCount, 3'd4);
    chk("full_cmdReady", cmdReady, 1'b0);
    chk("model_cq_size", cq.size(), 4);
    cmdX = 32'hDEAD_BEEF;
    step();
    chk("fifth_cmdCount", cmdCount, 3'd4);
    chk("head_jobX", jobX, 32'h0000_1000);
    chk("model_head_x", cq[0].x, 32'h0000_1000);

    // Issue all four, return four results with outReady low: credit exhausted.
    cmdValid = 1'b0; jobReady = 1'b1;
    for (int i = 0; i < D; i++) step();
    jobReady = 1'b0; resValid = 1'b1;
    for (int i = 0; i < D; i++) begin rand_data(); step(); end
    resValid = 1'b0; cmdValid = 1'b1; rand_data();
    step();
    cmdValid = 1'b0;
    step();
    chk("nocredit_jobValid", jobValid, 1'b0);
    chk("nocredit_resCount", resCount, 3'd4);
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    #1 chk("credit_back_jobValid", jobValid, 1'b1);
    @(negedge clk);
    jobReady = 1'b1; step();
    jobReady = 1'b0; resValid = 1'b1; rand_data(); step();
    resValid = 1'b0; outReady = 1'b1;
    for (int i = 0; i < D + 1; i++) step();
    outReady = 1'b0;
    chk("drain_resCount", resCount, 3'd0);

    // Stray result.
    do_reset();
    resValid = 1'b1; rand_data(); step();
    resValid = 1'b0;
    chk("stray_error", error, 1'b1);
    chk("stray_resCount", resCount, 3'd0);
    step(); step(); step();
    chk("stray_sticky", error, 1'b1);

    // Interrupt assert, clear on pop, clear on irqEnable falling.
    do_reset();
    irqEnable = 1'b1;
    cmdValid = 1'b1; rand_data(); step();
    cmdValid = 1'b0; jobReady = 1'b1; step();
    jobReady = 1'b0; resValid = 1'b1; rand_data(); step();
    resValid = 1'b0;
    chk("irq_set", interrupt, 1'b1);
    outReady = 1'b1; step();
    outReady = 1'b0;
    chk("irq_pop_clear", interrupt, 1'b0);
    cmdValid = 1'b1; rand_data(); step();
    cmdValid = 1'b0; jobReady = 1'b1; step();
    jobReady = 1'b0; resValid = 1'b1; rand_data(); step();
    resValid = 1'b0;
    chk("irq_set2", interrupt, 1'b1);
    irqEnable = 1'b0; step();
    chk("irq_disable_clear", interrupt, 1'b0);
    chk("irq_disable_outValid", outValid, 1'b1);

    // Reset mid-operation: two in flight, one result queued.
    do_reset();
    cmdValid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_data(); step(); end
    cmdValid = 1'b0; jobReady = 1'b1;
    for (int i = 0; i < 3; i++) step();
    jobReady = 1'b0; resValid = 1'b1; rand_data(); step();
    resValid = 1'b0;
    chk("pre_rst_resCount", resCount, 3'd1);
    rst = 1'b1; resValid = 1'b1; step();
    rst = 1'b0; resValid = 1'b0;
    chk("mid_rst_counts", {cmdCount, resCount}, 6'd0);
    chk("mid_rst_outValid", outValid, 1'b0);
    chk("mid_rst_error", error, 1'b0);
    resValid = 1'b1; rand_data(); step();
    resValid = 1'b0;
    chk("post_rst_stray", error, 1'b1);

`ifdef CORDIC_JOBQ_BYPASS_EN
    do_reset();
    jobReady = 1'b1; cmdValid = 1'b1; rand_data(); cmdZ = 32'h0C90_FDAA;
    #1;
    chk("bypass_jobValid", jobValid, 1'b1);
    chk("bypass_jobZ", jobZ, 32'h0C90_FDAA);
    step();
    idle();
    chk("bypass_cmdCount", cmdCount, 3'd0);
`endif

    // Randomized phases with varying handshake pressure.
    for (int ph = 0; ph < 8; ph++) begin
      int pc, pj, pr, po;
      pc = $urandom_range(15, 100);
      pj = $urandom_range(10, 100);
      pr = $urandom_range(10, 90);
      po = $urandom_range(10, 100);
      do_reset();
      for (int n = 0; n < 250; n++) begin
        rand_data();
        cmdValid  = ($urandom_range(0, 99) < pc);
        jobReady  = ($urandom_range(0, 99) < pj);
        outReady  = ($urandom_range(0, 99) < po);
        // Results mostly follow outstanding jobs; an occasional stray exercises error.
        resValid  = (m_inflight != 0) ? ($urandom_range(0, 99) < pr) : ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 15) == 0) irqEnable = ~irqEnable;
        rst = ($urandom_range(0, 199) == 0);
        step();
        rst = 1'b0;
      end
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
